router_scheduler: RTL and testbench

- Top-level sequencer that drives the input router and the weight router in lockstep for one convolution layer.
- Iterates over input-channel tiles. For each tile it computes SPAD address windows, clears and launches both routers, and waits until both report ready.
- It then issues a shared pop enable, with stall backpressure from the array, until both routers finish.
- Drives accumulator clear/flush and reports layer completion or a watchdog error.

---
 rtl/router_sched_pkg.sv | 20 ++
 rtl/tile_addr_calc.sv | 50 +++++
 rtl/router_scheduler.sv | 193 +++++++++++++++++++
 tb/tb_router_scheduler.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/router_sched_pkg.sv
// Shared types and default widths for the layer sequencer that drives the
// input and weight routers.
package router_sched_pkg;

    localparam int ADDR_WIDTH_DEF     = 8;
    localparam int TILE_CNT_WIDTH_DEF = 8;
    localparam int TIMEOUT_CYCLES_DEF = 1024;

    typedef enum logic [2:0] {
        IDLE,
        CONFIG,
        LAUNCH,
        WAIT_READY,
        STREAM,
        NEXT,
        FLUSH,
        DONE
    } sched_state_e;

endpackage

// File: rtl/tile_addr_calc.sv
// Per-router SPAD window generator: an offset accumulator replaces
// base + idx*len, and start/end are registered ahead of the CONFIG cycle.
module tile_addr_calc
    import router_sched_pkg::*;
#(
    parameter int AW = ADDR_WIDTH_DEF
) (
    input  logic          i_clk,
    input  logic          i_nrst,
    input  logic          i_load,
    input  logic          i_advance,
    input  logic [AW-1:0] i_base,
    input  logic [AW-1:0] i_len,
    output logic [AW-1:0] o_start_addr,
    output logic [AW-1:0] o_addr_end
);

    logic [AW-1:0] len_q;
    logic [AW-1:0] offset_q;
    logic [AW-1:0] start_q;
    logic [AW-1:0] end_q;
    logic [AW-1:0] len_eff;
    logic [AW-1:0] offset_d;

    assign len_eff  = (i_len == '0) ? AW'(1) : i_len;
    assign offset_d = offset_q + len_q;

    // All sums wrap modulo 2^AW by construction.
    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            len_q    <= '0;
            offset_q <= '0;
            start_q  <= '0;
            end_q    <= '0;
        end else if (i_load) begin
            len_q    <= len_eff;
            offset_q <= i_base;
            start_q  <= i_base;
            end_q    <= i_base + len_eff - AW'(1);
        end else if (i_advance) begin
            offset_q <= offset_d;
            start_q  <= offset_d;
            end_q    <= offset_d + len_q - AW'(1);
        end
    end

    assign o_start_addr = start_q;
    assign o_addr_end   = end_q;

endmodule

// File: rtl/router_scheduler.sv
// Layer sequencer: walks channel tiles, launches both routers in lockstep,
// streams shared pops until both finish, then flushes the accumulators.
//
// state      | meaning
// IDLE       | waiting for i_start, config latched on start
// CONFIG     | router clear, tile windows valid, acc clear on tile 0
// LAUNCH     | launch pulse to both routers, done flags/watchdog cleared
// WAIT_READY | waiting for both readies, watchdog running
// STREAM     | pop while not stalled, collecting sticky done flags
// NEXT       | advance to next tile or go flush
// FLUSH      | accumulator flush pulse
// DONE       | layer done pulse
module router_scheduler
    import router_sched_pkg::*;
#(
    parameter int ADDR_WIDTH     = ADDR_WIDTH_DEF,
    parameter int TILE_CNT_WIDTH = TILE_CNT_WIDTH_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                      i_clk,
    input  logic                      i_nrst,
    input  logic                      i_start,
    input  logic                      i_abort,
    input  logic [TILE_CNT_WIDTH-1:0] i_tile_count,
    input  logic [ADDR_WIDTH-1:0]     i_ir_base,
    input  logic [ADDR_WIDTH-1:0]     i_ir_tile_len,
    input  logic [ADDR_WIDTH-1:0]     i_wr_base,
    input  logic [ADDR_WIDTH-1:0]     i_wr_tile_len,
    input  logic                      i_ir_ready,
    input  logic                      i_ir_done,
    input  logic                      i_wr_ready,
    input  logic                      i_wr_done,
    input  logic                      i_stall,
    output logic                      o_ir_en,
    output logic                      o_wr_en,
    output logic                      o_router_clear,
    output logic [ADDR_WIDTH-1:0]     o_ir_start_addr,
    output logic [ADDR_WIDTH-1:0]     o_ir_addr_end,
    output logic [ADDR_WIDTH-1:0]     o_wr_start_addr,
    output logic [ADDR_WIDTH-1:0]     o_wr_addr_end,
    output logic                      o_pop_en,
    output logic                      o_acc_clear,
    output logic                      o_acc_flush,
    output logic [TILE_CNT_WIDTH-1:0] o_tile_idx,
    output logic                      o_busy,
    output logic                      o_done,
    output logic                      o_error
);

    localparam int WDOG_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_CYCLES - 1);

    sched_state_e              state_q;
    logic [TILE_CNT_WIDTH-1:0] tile_idx_q;
    logic [TILE_CNT_WIDTH-1:0] count_q;
    logic [WDOG_W-1:0]         wdog_q;
    logic                      ir_flag_q, wr_flag_q;
    logic                      ir_flag_d, wr_flag_d;
    logic                      ir_en_q, wr_en_q, router_clear_q;
    logic                      acc_clear_q, acc_flush_q, done_q, error_q;
    logic                      last_tile;
    logic                      addr_load, addr_adv;

    assign ir_flag_d = ir_flag_q | i_ir_done;
    assign wr_flag_d = wr_flag_q | i_wr_done;
    assign last_tile = (tile_idx_q == count_q - TILE_CNT_WIDTH'(1));
    assign addr_load = (state_q == IDLE) && i_start && !i_abort;
    assign addr_adv  = (state_q == NEXT) && !last_tile && !i_abort;

    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            state_q        <= IDLE;
            tile_idx_q     <= '0;
            count_q        <= '0;
            wdog_q         <= '0;
            ir_flag_q      <= 1'b0;
            wr_flag_q      <= 1'b0;
            ir_en_q        <= 1'b0;
            wr_en_q        <= 1'b0;
            router_clear_q <= 1'b0;
            acc_clear_q    <= 1'b0;
            acc_flush_q    <= 1'b0;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
        end else begin
            ir_en_q        <= 1'b0;
            wr_en_q        <= 1'b0;
            router_clear_q <= 1'b0;
            acc_clear_q    <= 1'b0;
            acc_flush_q    <= 1'b0;
            done_q         <= 1'b0;
            if (i_abort) begin
                state_q        <= IDLE;
                router_clear_q <= 1'b1;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (i_start) begin
                            count_q        <= (i_tile_count == '0) ? TILE_CNT_WIDTH'(1) : i_tile_count;
                            tile_idx_q     <= '0;
                            error_q        <= 1'b0;
                            router_clear_q <= 1'b1;
                            acc_clear_q    <= 1'b1;
                            state_q        <= CONFIG;
                        end
                    end
                    CONFIG: begin
                        ir_en_q <= 1'b1;
                        wr_en_q <= 1'b1;
                        state_q <= LAUNCH;
                    end
                    LAUNCH: begin
                        ir_flag_q <= 1'b0;
                        wr_flag_q <= 1'b0;
                        wdog_q    <= '0;
                        state_q   <= WAIT_READY;
                    end
                    WAIT_READY: begin
                        if (i_ir_ready && i_wr_ready) begin
                            state_q <= STREAM;
                        end else if (wdog_q == WDOG_LAST) begin
                            error_q <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            wdog_q <= wdog_q + WDOG_W'(1);
                        end
                    end
                    STREAM: begin
                        ir_flag_q <= ir_flag_d;
                        wr_flag_q <= wr_flag_d;
                        if (ir_flag_d && wr_flag_d) begin
                            state_q <= NEXT;
                        end
                    end
                    NEXT: begin
                        if (last_tile) begin
                            acc_flush_q <= 1'b1;
                            state_q     <= FLUSH;
                        end else begin
                            tile_idx_q     <= tile_idx_q + TILE_CNT_WIDTH'(1);
                            router_clear_q <= 1'b1;
                            state_q        <= CONFIG;
                        end
                    end
                    FLUSH: begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                    DONE: begin
                        state_q <= IDLE;
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    tile_addr_calc #(.AW(ADDR_WIDTH)) u_ir_addr (
        .i_clk        (i_clk),
        .i_nrst       (i_nrst),
        .i_load       (addr_load),
        .i_advance    (addr_adv),
        .i_base       (i_ir_base),
        .i_len        (i_ir_tile_len),
        .o_start_addr (o_ir_start_addr),
        .o_addr_end   (o_ir_addr_end)
    );

    tile_addr_calc #(.AW(ADDR_WIDTH)) u_wr_addr (
        .i_clk        (i_clk),
        .i_nrst       (i_nrst),
        .i_load       (addr_load),
        .i_advance    (addr_adv),
        .i_base       (i_wr_base),
        .i_len        (i_wr_tile_len),
        .o_start_addr (o_wr_start_addr),
        .o_addr_end   (o_wr_addr_end)
    );

    assign o_pop_en       = (state_q == STREAM) && !i_stall;
    assign o_busy         = (state_q != IDLE);
    assign o_ir_en        = ir_en_q;
    assign o_wr_en        = wr_en_q;
    assign o_router_clear = router_clear_q;
    assign o_acc_clear    = acc_clear_q;
    assign o_acc_flush    = acc_flush_q;
    assign o_done         = done_q;
    assign o_error        = error_q;
    assign o_tile_idx     = tile_idx_q;

endmodule

// File: tb/tb_router_scheduler.sv
// Directed bench for router_scheduler: single/multi-tile runs, stall and
// skewed dones, watchdog, abort, busy start and mid-run reset.
module tb_router_scheduler;

    logic       clk = 1'b0;
    logic       nrst, start, abort;
    logic [7:0] tile_count, ir_base, ir_len, wr_base, wr_len;
    logic       ir_ready, ir_done, wr_ready, wr_done, stall;
    logic       ir_en, wr_en, router_clear, pop_en, acc_clear, acc_flush;
    logic       busy, done, error;
    logic [7:0] ir_s, ir_e, wr_s, wr_e, tile_idx;

    int pass_cnt = 0;
    int total_cnt = 0;
    int n_flush = 0;
    int n_clear = 0;

    // status order: router_clear acc_clear ir_en wr_en pop_en acc_flush done busy error
    logic [8:0] st;
    assign st = {router_clear, acc_clear, ir_en, wr_en, pop_en, acc_flush, done, busy, error};

    always #5 clk = ~clk;

    router_scheduler #(
        .ADDR_WIDTH     (8),
        .TILE_CNT_WIDTH (8),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .i_clk           (clk),
        .i_nrst          (nrst),
        .i_start         (start),
        .i_abort         (abort),
        .i_tile_count    (tile_count),
        .i_ir_base       (ir_base),
        .i_ir_tile_len   (ir_len),
        .i_wr_base       (wr_base),
        .i_wr_tile_len   (wr_len),
        .i_ir_ready      (ir_ready),
        .i_ir_done       (ir_done),
        .i_wr_ready      (wr_ready),
        .i_wr_done       (wr_done),
        .i_stall         (stall),
        .o_ir_en         (ir_en),
        .o_wr_en         (wr_en),
        .o_router_clear  (router_clear),
        .o_ir_start_addr (ir_s),
        .o_ir_addr_end   (ir_e),
        .o_wr_start_addr (wr_s),
        .o_wr_addr_end   (wr_e),
        .o_pop_en        (pop_en),
        .o_acc_clear     (acc_clear),
        .o_acc_flush     (acc_flush),
        .o_tile_idx      (tile_idx),
        .o_busy          (busy),
        .o_done          (done),
        .o_error         (error)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        if (acc_flush) n_flush++;
        if (acc_clear) n_clear++;
    endtask

    task automatic test_reset();
        nrst = 1'b0; start = 1'b0; abort = 1'b0; tile_count = 8'd0;
        ir_base = 8'd0; ir_len = 8'd0; wr_base = 8'd0; wr_len = 8'd0;
        ir_ready = 1'b0; ir_done = 1'b0; wr_ready = 1'b0; wr_done = 1'b0; stall = 1'b0;
        tick(); tick();
        total_cnt++;
        if (st !== 9'b0) $display("FAIL reset_status: got %b expected %b", st, 9'b0);
        else pass_cnt++;
        total_cnt++;
        if ({ir_s, ir_e, wr_s, wr_e, tile_idx} !== 40'h0)
            $display("FAIL reset_addr: got %h expected %h", {ir_s, ir_e, wr_s, wr_e, tile_idx}, 40'h0);
        else pass_cnt++;
        nrst = 1'b1;
        tick();
    endtask

    task automatic test_single_tile();
        tile_count = 8'd1; ir_base = 8'h10; ir_len = 8'd4; wr_base = 8'h20; wr_len = 8'd2;
        ir_ready = 1'b1; wr_ready = 1'b1; stall = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        total_cnt++;
        if (st !== 9'b110000010) $display("FAIL single_config: got %b expected %b", st, 9'b110000010);
        else pass_cnt++;
        total_cnt++;
        if ({ir_s, ir_e, wr_s, wr_e} !== 32'h10132021)
            $display("FAIL single_addr: got %h expected %h", {ir_s, ir_e, wr_s, wr_e}, 32'h10132021);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (st !== 9'b001100010) $display("FAIL single_launch: got %b expected %b", st, 9'b001100010);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (st !== 9'b000000010) $display("FAIL single_wait: got %b expected %b", st, 9'b000000010);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (st !== 9'b000010010) $display("FAIL single_stream: got %b expected %b", st, 9'b000010010);
        else pass_cnt++;
        ir_done = 1'b1; wr_done = 1'b1;
        tick();
        ir_done = 1'b0; wr_done = 1'b0;
        total_cnt++;
        if (st !== 9'b000000010) $display("FAIL single_next: got %b expected %b", st, 9'b000000010);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (st !== 9'b000001010) $display("FAIL single_flush: got %b expected %b", st, 9'b000001010);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (st !== 9'b000000110) $display("FAIL single_done: got %b expected %b", st, 9'b000000110);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (st !== 9'b0) $display("FAIL single_idle: got %b expected %b", st, 9'b0);
        else pass_cnt++;
    endtask

    // ir_len = 0 behaves as 1; config changes and a start pulse mid-run are ignored.
    task automatic test_three_tiles();
        logic [7:0] exp_ws [3];
        logic [7:0] exp_we [3];
        exp_ws = '{8'hF8, 8'h00, 8'h08};
        exp_we = '{8'hFF, 8'h07, 8'h0F};
        tile_count = 8'd3; ir_base = 8'h00; ir_len = 8'd0; wr_base = 8'hF8; wr_len = 8'd8;
        ir_ready = 1'b1; wr_ready = 1'b1; stall = 1'b0;
        n_flush = 0; n_clear = 0;
        start = 1'b1; tick(); start = 1'b0;
        for (int t = 0; t < 3; t++) begin
            total_cnt++;
            if ({tile_idx, ir_s, ir_e, router_clear} !== {8'(t), 8'(t), 8'(t), 1'b1})
                $display("FAIL tiles_ir_t%0d: got %h expected %h", t,
                         {tile_idx, ir_s, ir_e, router_clear}, {8'(t), 8'(t), 8'(t), 1'b1});
            else pass_cnt++;
            total_cnt++;
            if ({wr_s, wr_e} !== {exp_ws[t], exp_we[t]})
                $display("FAIL tiles_wr_t%0d: got %h expected %h", t, {wr_s, wr_e}, {exp_ws[t], exp_we[t]});
            else pass_cnt++;
            tick();
            if (t == 0) begin
                tile_count = 8'd1; wr_base = 8'h55; ir_len = 8'd9; start = 1'b1;
            end
            tick();
            start = 1'b0;
            tick();
            total_cnt++;
            if (pop_en !== 1'b1) $display("FAIL tiles_pop_t%0d: got %b expected %b", t, pop_en, 1'b1);
            else pass_cnt++;
            ir_done = 1'b1; wr_done = 1'b1;
            tick();
            ir_done = 1'b0; wr_done = 1'b0;
            tick();
        end
        total_cnt++;
        if (acc_flush !== 1'b1) $display("FAIL tiles_flush: got %b expected %b", acc_flush, 1'b1);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (done !== 1'b1) $display("FAIL tiles_done: got %b expected %b", done, 1'b1);
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({n_flush, n_clear} !== {32'd1, 32'd1})
            $display("FAIL tiles_pulse_counts: got flush=%0d clear=%0d expected flush=1 clear=1", n_flush, n_clear);
        else pass_cnt++;
    endtask

    task automatic test_stall_skew();
        tile_count = 8'd1; ir_base = 8'h40; ir_len = 8'd16; wr_base = 8'h80; wr_len = 8'd16;
        ir_ready = 1'b1; wr_ready = 1'b1; stall = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        tick();
        wr_ready = 1'b0; ir_done = 1'b1; wr_done = 1'b1;
        tick(); tick(); tick();
        total_cnt++;
        if (st !== 9'b000000010) $display("FAIL skew_wait: got %b expected %b", st, 9'b000000010);
        else pass_cnt++;
        ir_done = 1'b0; wr_done = 1'b0; wr_ready = 1'b1;
        tick();
        for (int k = 0; k < 16; k++) begin
            stall   = k[0];
            ir_done = (k == 10);
            wr_done = (k == 15);
            #1;
            total_cnt++;
            if (pop_en !== ~stall) $display("FAIL skew_pop_k%0d: got %b expected %b", k, pop_en, ~stall);
            else pass_cnt++;
            tick();
        end
        ir_done = 1'b0; wr_done = 1'b0; stall = 1'b0;
        #1;
        total_cnt++;
        if (st !== 9'b000000010) $display("FAIL skew_next: got %b expected %b", st, 9'b000000010);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (acc_flush !== 1'b1) $display("FAIL skew_flush: got %b expected %b", acc_flush, 1'b1);
        else pass_cnt++;
        tick(); tick();
    endtask

    task automatic test_watchdog_abort();
        tile_count = 8'd2; ir_base = 8'h30; ir_len = 8'd4; wr_base = 8'h60; wr_len = 8'd4;
        ir_ready = 1'b1; wr_ready = 1'b0; stall = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        tick(); tick();
        for (int j = 0; j < 15; j++) begin
            tick();
            total_cnt++;
            if ({busy, error} !== 2'b10)
                $display("FAIL wdog_pending_%0d: got %b expected %b", j, {busy, error}, 2'b10);
            else pass_cnt++;
        end
        tick();
        total_cnt++;
        if (st !== 9'b000000001) $display("FAIL wdog_error: got %b expected %b", st, 9'b000000001);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (st !== 9'b000000001) $display("FAIL wdog_sticky: got %b expected %b", st, 9'b000000001);
        else pass_cnt++;
        wr_ready = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        total_cnt++;
        if (st !== 9'b110000010) $display("FAIL wdog_restart: got %b expected %b", st, 9'b110000010);
        else pass_cnt++;
        tick(); tick(); tick();
        total_cnt++;
        if (pop_en !== 1'b1) $display("FAIL abort_pre_pop: got %b expected %b", pop_en, 1'b1);
        else pass_cnt++;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        total_cnt++;
        if (st !== 9'b100000000) $display("FAIL abort_stream: got %b expected %b", st, 9'b100000000);
        else pass_cnt++;
        total_cnt++;
        if ({ir_s, ir_e, wr_s, wr_e, tile_idx} !== 40'h3033606300)
            $display("FAIL abort_hold: got %h expected %h", {ir_s, ir_e, wr_s, wr_e, tile_idx}, 40'h3033606300);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (st !== 9'b0) $display("FAIL abort_settle: got %b expected %b", st, 9'b0);
        else pass_cnt++;
        start = 1'b1; tick(); start = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        total_cnt++;
        if (st !== 9'b100000000) $display("FAIL abort_config: got %b expected %b", st, 9'b100000000);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_reset_midrun();
        tile_count = 8'd3; ir_base = 8'h10; ir_len = 8'd4; wr_base = 8'h20; wr_len = 8'd4;
        ir_ready = 1'b1; wr_ready = 1'b1; stall = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        tick(); tick(); tick();
        ir_done = 1'b1; wr_done = 1'b1;
        tick();
        ir_done = 1'b0; wr_done = 1'b0;
        tick();
        total_cnt++;
        if ({tile_idx, ir_s, wr_e} !== 24'h011427)
            $display("FAIL midrun_tile1: got %h expected %h", {tile_idx, ir_s, wr_e}, 24'h011427);
        else pass_cnt++;
        tick();
        nrst = 1'b0;
        tick();
        total_cnt++;
        if ({st, ir_s, ir_e, wr_s, wr_e, tile_idx} !== 49'h0)
            $display("FAIL midrun_reset: got %h expected %h", {st, ir_s, ir_e, wr_s, wr_e, tile_idx}, 49'h0);
        else pass_cnt++;
        nrst = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_tile();
        test_three_tiles();
        test_stall_skew();
        test_watchdog_abort();
        test_reset_midrun();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
